// File: rtl/svfloat_sched_pkg.sv
// Shared types for the float-unit scheduler: op encoding, reservation entry, op latency lookup.
// Combinational helpers only, no latency.
// No flow control lives here; the scheduler and reservation vector use these types.
package svfloat_sched_pkg;

  typedef enum logic [1:0] {
    OP_MUL = 2'd0,
    OP_DIV = 2'd1,
    OP_ADD = 2'd2,
    OP_SUB = 2'd3
  } sched_op_t;

  // Entries carry a fixed-width tag; the scheduler uses the low TAG_W bits.
  localparam int TAG_MAX = 16;

  typedef struct packed {
    logic                busy;
    sched_op_t           op;
    logic [TAG_MAX-1:0]  tag;
  } resv_entry_t;

  function automatic int op_lat(sched_op_t op, int lat_mul, int lat_div, int lat_add);
    case (op)
      OP_MUL:  return lat_mul;
      OP_DIV:  return lat_div;
      default: return lat_add;
    endcase
  endfunction

endpackage

// File: rtl/svfloat_sched_resv.sv
// Writeback reservation shift register: shifts toward slot 0, claims slot LAT(op) post-shift.
// Slot 0 is the entry retiring this cycle; claims land one edge after the accept.
// slot_free reports whether the requested op's writeback slot is open; clr empties every slot.
module svfloat_sched_resv
  import svfloat_sched_pkg::*;
#(
  parameter int LAT_MUL = 2,
  parameter int LAT_DIV = 8,
  parameter int LAT_ADD = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               claim,
  input  sched_op_t          claim_op,
  input  logic [TAG_MAX-1:0] claim_tag,
  output logic               slot_free,
  output resv_entry_t        head
);

  localparam int MAX_MD = (LAT_MUL > LAT_DIV) ? LAT_MUL : LAT_DIV;
  localparam int MAXLAT = (MAX_MD > LAT_ADD) ? MAX_MD : LAT_ADD;
  localparam int IW     = $clog2(MAXLAT + 1);

  resv_entry_t       resv      [MAXLAT+1];
  resv_entry_t       resv_next [MAXLAT+1];
  logic [IW-1:0]     lat_idx;

  assign lat_idx = IW'(op_lat(claim_op, LAT_MUL, LAT_DIV, LAT_ADD));

  always_comb begin
    for (int i = 0; i < MAXLAT; i++) begin
      resv_next[i] = resv[i+1];
    end
    resv_next[MAXLAT] = '0;
  end

  // Checked against the post-shift view so a slot vacated this edge can be reused at once.
  assign slot_free = !resv_next[lat_idx].busy;
  assign head      = resv[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= MAXLAT; i++) resv[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i <= MAXLAT; i++) resv[i] <= '0;
    end else begin
      for (int i = 0; i <= MAXLAT; i++) begin
        if (claim && (i == int'(lat_idx)))
          resv[i] <= '{busy: 1'b1, op: claim_op, tag: claim_tag};
        else
          resv[i] <= resv_next[i];
      end
    end
  end

endmodule

// File: rtl/svfloat_sched.sv
// Single-issue scheduler sharing one operand bus across mul/div/add/sub; optional SVFLOAT_SCHED_FLUSH_EN adds flush.
// Result appears LAT(op)+1 cycles after accept, one res_valid pulse per op.
// req_ready drops on a writeback-slot collision or DIV_II spacing; results have no backpressure.
module svfloat_sched
  import svfloat_sched_pkg::*;
#(
  parameter int LAT_MUL = 2,
  parameter int LAT_DIV = 8,
  parameter int LAT_ADD = 3,
  parameter int DIV_II  = 1,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SVFLOAT_SCHED_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [TAG_W-1:0] req_tag,
  input  logic [31:0]      req_lhs,
  input  logic [31:0]      req_rhs,
  output logic [31:0]      op_lhs,
  output logic [31:0]      op_rhs,
  input  logic [31:0]      mul_res,
  input  logic [31:0]      div_res,
  input  logic [31:0]      add_res,
  input  logic [31:0]      sub_res,
  output logic             res_valid,
  output logic [1:0]       res_op,
  output logic [TAG_W-1:0] res_tag,
  output logic [31:0]      res_data
);

  localparam int CW = (DIV_II > 1) ? $clog2(DIV_II) : 1;

  sched_op_t   op_in;
  logic        kill;
  logic        slot_free;
  logic        div_block;
  logic        accept;
  logic [CW-1:0] div_cnt;
  resv_entry_t head;
  logic [31:0] unit_res;

  assign op_in = sched_op_t'(req_op);

`ifdef SVFLOAT_SCHED_FLUSH_EN
  assign kill = flush;
`else
  assign kill = 1'b0;
`endif

  assign div_block = (op_in == OP_DIV) && (div_cnt != '0);
  assign req_ready = rst_n && !kill && slot_free && !div_block;
  assign accept    = req_valid && req_ready;

  svfloat_sched_resv #(
    .LAT_MUL (LAT_MUL),
    .LAT_DIV (LAT_DIV),
    .LAT_ADD (LAT_ADD)
  ) u_resv (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (kill),
    .claim     (accept),
    .claim_op  (op_in),
    .claim_tag (TAG_MAX'(req_tag)),
    .slot_free (slot_free),
    .head      (head)
  );

  always_comb begin
    unit_res = add_res;
    case (head.op)
      OP_MUL:  unit_res = mul_res;
      OP_DIV:  unit_res = div_res;
      OP_ADD:  unit_res = add_res;
      OP_SUB:  unit_res = sub_res;
      default: unit_res = add_res;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_lhs    <= '0;
      op_rhs    <= '0;
      div_cnt   <= '0;
      res_valid <= 1'b0;
      res_op    <= '0;
      res_tag   <= '0;
      res_data  <= '0;
    end else begin
      if (accept) begin
        op_lhs <= req_lhs;
        op_rhs <= req_rhs;
      end
      if (kill)
        div_cnt <= '0;
      else if (accept && (op_in == OP_DIV))
        div_cnt <= CW'(DIV_II - 1);
      else if (div_cnt != '0)
        div_cnt <= div_cnt - 1'b1;
      // Slot 0 retires now; its unit has had exactly LAT cycles since the operands registered.
      res_valid <= head.busy && !kill;
      if (head.busy && !kill) begin
        res_op   <= head.op;
        res_tag  <= head.tag[TAG_W-1:0];
        res_data <= unit_res;
      end
    end
  end

endmodule

// File: tb/tb_svfloat_sched.sv
// Scoreboard bench for svfloat_sched: directed ops with hand-computed float results and cycles.
module tb_svfloat_sched;
  import svfloat_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, v4;
  logic        req_ready, rdy4;
  logic [1:0]  req_op;
  logic [3:0]  req_tag;
  logic [31:0] req_lhs, req_rhs;
  logic [31:0] op_lhs, op_rhs, lhs4, rhs4;
  logic [31:0] mul_res, div_res, add_res, sub_res;
  logic        res_valid, rv4;
  logic [1:0]  res_op, rop4;
  logic [3:0]  res_tag, rtag4;
  logic [31:0] res_data, rdata4;
`ifdef SVFLOAT_SCHED_FLUSH_EN
  logic        flush;
`endif

  always #5 clk = ~clk;

  svfloat_sched dut (
    .clk(clk), .rst_n(rst_n),
`ifdef SVFLOAT_SCHED_FLUSH_EN
    .flush(flush),
`endif
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_tag(req_tag),
    .req_lhs(req_lhs), .req_rhs(req_rhs), .op_lhs(op_lhs), .op_rhs(op_rhs),
    .mul_res(mul_res), .div_res(div_res), .add_res(add_res), .sub_res(sub_res),
    .res_valid(res_valid), .res_op(res_op), .res_tag(res_tag), .res_data(res_data)
  );

  svfloat_sched #(.DIV_II(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
`ifdef SVFLOAT_SCHED_FLUSH_EN
    .flush(1'b0),
`endif
    .req_valid(v4), .req_ready(rdy4), .req_op(req_op), .req_tag(req_tag),
    .req_lhs(req_lhs), .req_rhs(req_rhs), .op_lhs(lhs4), .op_rhs(rhs4),
    .mul_res(32'h0), .div_res(32'h4040_0000), .add_res(32'h0), .sub_res(32'h0),
    .res_valid(rv4), .res_op(rop4), .res_tag(rtag4), .res_data(rdata4)
  );

  // Stand-in float units: lookup of the vectors used here, distinct NaN payloads otherwise.
  function automatic logic [31:0] f_mul(logic [31:0] a, logic [31:0] b);
    case ({a, b})
      64'h40000000_40400000: return 32'h40C00000;
      64'h40C00000_40000000: return 32'h41400000;
      default:               return 32'h7FC00001;
    endcase
  endfunction
  function automatic logic [31:0] f_div(logic [31:0] a, logic [31:0] b);
    case ({a, b})
      64'h40C00000_40000000: return 32'h40400000;
      default:               return 32'h7FC00002;
    endcase
  endfunction
  function automatic logic [31:0] f_add(logic [31:0] a, logic [31:0] b);
    case ({a, b})
      64'h3F800000_40000000: return 32'h40400000;
      64'h40C00000_40000000: return 32'h41000000;
      default:               return 32'h7FC00003;
    endcase
  endfunction
  function automatic logic [31:0] f_sub(logic [31:0] a, logic [31:0] b);
    case ({a, b})
      64'h3F800000_40000000: return 32'hBF800000;
      64'h40C00000_40000000: return 32'h40800000;
      default:               return 32'h7FC00004;
    endcase
  endfunction

  logic [31:0] mul_p [2];
  logic [31:0] div_p [8];
  logic [31:0] add_p [3];
  logic [31:0] sub_p [3];

  always @(posedge clk) begin
    mul_p[0] <= f_mul(op_lhs, op_rhs);
    div_p[0] <= f_div(op_lhs, op_rhs);
    add_p[0] <= f_add(op_lhs, op_rhs);
    sub_p[0] <= f_sub(op_lhs, op_rhs);
    mul_p[1] <= mul_p[0];
    for (int i = 1; i < 8; i++) div_p[i] <= div_p[i-1];
    for (int i = 1; i < 3; i++) begin
      add_p[i] <= add_p[i-1];
      sub_p[i] <= sub_p[i-1];
    end
  end
  assign mul_res = mul_p[1];
  assign div_res = div_p[7];
  assign add_res = add_p[2];
  assign sub_res = sub_p[2];

  typedef struct {
    int          cyc;
    logic [1:0]  op;
    logic [3:0]  tag;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   n4    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h, want %h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: match each result strobe to the scoreboard entry due this cycle.
  always @(negedge clk) begin
    if (res_valid === 1'b1) begin
      int idx;
      idx = -1;
      foreach (sb[i]) if (sb[i].cyc == cyc) idx = i;
      if (idx < 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result @cyc %0d: got tag %h data %h, want no res_valid", cyc, res_tag, res_data);
      end else begin
        chk("res_op", 32'(res_op), 32'(sb[idx].op));
        chk("res_tag", 32'(res_tag), 32'(sb[idx].tag));
        chk("res_data", res_data, sb[idx].data);
        sb.delete(idx);
      end
    end
    if (rv4 === 1'b1) n4++;
  end

  function automatic int lat(logic [1:0] op);
    case (op)
      2'd0:    return 2;
      2'd1:    return 8;
      default: return 3;
    endcase
  endfunction

  // One cycle of offer: drive at negedge, check ready, schedule the expected result if accepted.
  task automatic offer(input logic [1:0] op, input logic [3:0] tag, input logic [31:0] l,
                       input logic [31:0] r, input logic [31:0] d, input logic exp_rdy);
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_tag   = tag;
    req_lhs   = l;
    req_rhs   = r;
    #1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (req_ready) begin
      e.cyc  = cyc + 1 + lat(op) + 1;
      e.op   = op;
      e.tag  = tag;
      e.data = d;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, "_ready"}, 32'(req_ready), 32'h0);
    chk({nm, "_op_lhs"}, op_lhs, 32'h0);
    chk({nm, "_op_rhs"}, op_rhs, 32'h0);
    chk({nm, "_res_valid"}, 32'(res_valid), 32'h0);
    chk({nm, "_res_op"}, 32'(res_op), 32'h0);
    chk({nm, "_res_tag"}, 32'(res_tag), 32'h0);
    chk({nm, "_res_data"}, res_data, 32'h0);
  endtask

  initial begin
    bit [8:0] pat;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    v4        = 1'b0;
    req_op    = 2'd0;
    req_tag   = 4'd0;
    req_lhs   = 32'h0;
    req_rhs   = 32'h0;
`ifdef SVFLOAT_SCHED_FLUSH_EN
    flush     = 1'b0;
`endif
    #2;
    chk_zero_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Basic MUL: result 3 cycles after accept.
    offer(2'd0, 4'd5, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b1);
    idle(6);

    // ADD then SUB back to back, results in consecutive cycles.
    offer(2'd2, 4'd1, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b1);
    offer(2'd3, 4'd2, 32'h3F800000, 32'h40000000, 32'hBF800000, 1'b1);
    idle(8);

    // Same op back to back.
    offer(2'd0, 4'd6, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b1);
    offer(2'd0, 4'd7, 32'h40C00000, 32'h40000000, 32'h41400000, 1'b1);
    idle(8);

    // Collision: DIV at t claims slot that MUL at t+6 would need.
    offer(2'd1, 4'd3, 32'h40C00000, 32'h40000000, 32'h40400000, 1'b1);
    idle(5);
    offer(2'd0, 4'd4, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0);
    offer(2'd0, 4'd4, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b1);
    idle(8);

    // Reorder: ADD issued after DIV returns first.
    offer(2'd1, 4'd7, 32'h40C00000, 32'h40000000, 32'h40400000, 1'b1);
    offer(2'd2, 4'd8, 32'h40C00000, 32'h40000000, 32'h41000000, 1'b1);
    idle(12);
    chk("drained_before_reset", sb.size(), 32'h0);

    // DIV_II=4 instance: divides every cycle accepted at t, t+4, t+8.
    pat = 9'b100010001;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      v4        = 1'b1;
      req_op    = 2'd1;
      req_tag   = 4'(i);
      req_lhs   = 32'h40C00000;
      req_rhs   = 32'h40000000;
      #1;
      chk("ii4_ready", 32'(rdy4), 32'(pat[i]));
    end
    @(negedge clk);
    v4 = 1'b0;
    idle(14);
    chk("ii4_results", n4, 32'd3);

    // Reset with three ops in flight: all dropped.
    offer(2'd0, 4'd9,  32'h40000000, 32'h40400000, 32'h40C00000, 1'b1);
    offer(2'd2, 4'd10, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b1);
    offer(2'd1, 4'd11, 32'h40C00000, 32'h40000000, 32'h40400000, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk_zero_outputs("midreset");
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(14);

    // Normal operation resumes after reset.
    offer(2'd3, 4'd12, 32'h40C00000, 32'h40000000, 32'h40800000, 1'b1);
    idle(6);

`ifdef SVFLOAT_SCHED_FLUSH_EN
    offer(2'd0, 4'd13, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b1);
    offer(2'd2, 4'd14, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b1);
    offer(2'd1, 4'd15, 32'h40C00000, 32'h40000000, 32'h40400000, 1'b1);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'd0;
    flush     = 1'b1;
    #1;
    chk("flush_ready", 32'(req_ready), 32'h0);
    sb.delete();
    @(negedge clk);
    flush     = 1'b0;
    req_valid = 1'b0;
    idle(14);
`endif

    chk("scoreboard_empty", sb.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/svfloat_sched.md
Name: svfloat_sched

Overview:
- Single-issue scheduler that shares one operand bus across the four fixed-latency float units: svfloat_mul, svfloat_div, svfloat_add, svfloat_sub.
- Accepts tagged operations over a valid/ready handshake and registers the operands once, feeding them to all units.
- Tracks in-flight work with a writeback reservation shift register, so results return on a single result port with no writeback collisions.
- Sits between the instruction front end and the float datapath.

Parameters:
- LAT_MUL, 2, cycles from operands at svfloat_mul input to its result; must be at least 1.
- LAT_DIV, 8, same for svfloat_div; must be at least 1.
- LAT_ADD, 3, same for svfloat_add and svfloat_sub (shared value); must be at least 1.
- DIV_II, 1, minimum cycles between two accepted divides; 1 means fully pipelined.
- TAG_W, 4, width of the requester tag.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when high together with req_valid
- req_op  in  2  0=MUL 1=DIV 2=ADD 3=SUB (sched_op_t)
- req_tag  in  TAG_W  requester tag
- req_lhs  in  32  binary32 lhs
- req_rhs  in  32  binary32 rhs
- op_lhs  out  32  registered lhs to all units
- op_rhs  out  32  registered rhs to all units
- mul_res  in  32  svfloat_mul output
- div_res  in  32  svfloat_div output
- add_res  in  32  svfloat_add output
- sub_res  in  32  svfloat_sub output
- res_valid  out  1  result strobe, one cycle per op
- res_op  out  2  op of the result
- res_tag  out  TAG_W  tag of the result
- res_data  out  32  result value

Behaviour:
- Reset (async assert, sync deassert) clears all state and every output: req_ready=0 while rst_n low; op_lhs, op_rhs, res_* all 0; reservation vector empty; DIV_II counter 0. Asserting reset mid-operation drops all in-flight ops; no res_valid follows.
- Accept at edge E (req_valid && req_ready): op_lhs/op_rhs load at E and are held until the next accept.
- The unit output is sampled LAT_x cycles after E+1. res_* registers and res_valid is high for exactly one cycle, LAT_x+1 cycles after E.
- Reservation vector resv[0..MAXLAT], MAXLAT = max of all latencies. It shifts toward 0 every cycle. Each entry holds {busy, op, tag}.
- An accept writes entry LAT_op, post-shift. Entry 0 busy drives the res_* update and selects the unit result by its stored op.
- req_ready = !resv_next[LAT(req_op)].busy && !(req_op==DIV && div_cnt!=0). Ready depends combinationally on req_op; requesters must not change req_op while waiting.
- div_cnt loads DIV_II-1 on a divide accept and decrements to 0.
- No result backpressure; the consumer must always sink res_valid.
- Simultaneous accept and retire in the same cycle are legal.
- Results return in writeback-slot order, not issue order.
- Back-to-back same-op issue is one per cycle when DIV_II=1.

Optional Feature:
- SVFLOAT_SCHED_FLUSH_EN defined: adds input flush (1 bit). When flush is high at an edge, all busy bits clear, no res_valid is produced for killed ops, div_cnt resets to 0, and req_ready is forced low that cycle.
- Undefined: no flush port and no flush logic.

Decomposition:
- Package svfloat_sched_pkg: sched_op_t enum (MUL, DIV, ADD, SUB), a resv_entry_t struct {busy, op, tag}, and a function returning the latency for an op.
- The reservation vector is the natural sub-module: svfloat_sched_resv (shift, claim, retire).

Test Plan:
- Basic MUL: lhs=0x40000000, rhs=0x40400000, tag 5 -> res_valid exactly 3 cycles after accept, res_data=0x40C00000, res_tag=5.
- Ops in consecutive cycles:
  - ADD 0x3F800000+0x40000000 -> 0x40400000.
  - SUB same operands -> 0xBF800000.
  - Both results come back in consecutive cycles, in issue order.
- Collision:
  - DIV 0x40C00000/0x40000000 at cycle t, then MUL offered at t+6 -> req_ready=0 at t+6.
  - MUL accepted at t+7.
  - DIV result 0x40400000 at t+9, MUL at t+10.
- Reorder: DIV at t, ADD at t+1 -> ADD result first (t+5), DIV result at t+9. Tags match ops.
- DIV_II=4: divides requested every cycle -> accepted at t, t+4, t+8. req_ready low between.
- Reset with 3 ops in flight -> no res_valid afterwards, all outputs 0. With SVFLOAT_SCHED_FLUSH_EN, flush gives the same result without reset.
